pipe_ctrl: RTL

- Pipeline control unit for the 5-stage core.
- Consumes the decode/execute register outputs (EX-stage load, destination, PC source) plus IF/ID operand selects, the EX/MEM memory request and the cache hit strobes.
- Drives the stage enables (including id_en of the decode/execute register) and the bubble/flush controls.
- Handles memory-wait freeze, load-use stall, taken-branch/jump flush, hit capture and halt.

---
 rtl/diaosi_types_pkg.sv | 15 +
 rtl/load_use_detect.sv | 21 ++
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/diaosi_types_pkg.sv
// Shared types and constants for the core pipeline control slice.
package diaosi_types_pkg;

  localparam int unsigned REG_W = 5;

  // Register 0 is hard-wired zero, so it never carries a load-use hazard.
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: an EX-stage load whose destination feeds the IF/ID operands.
module load_use_detect
  import diaosi_types_pkg::*;
#(
  parameter int unsigned REGBITS = REG_W
) (
  input  logic               d_ren_ex,
  input  logic [REGBITS-1:0] wsel_ex,
  input  logic [REGBITS-1:0] rs_id,
  input  logic [REGBITS-1:0] rt_id,
  output logic               lu_c
);

  logic w_dest_live;
  logic w_src_match;

  assign w_dest_live = d_ren_ex && (wsel_ex != REGBITS'(REG_ZERO));
  assign w_src_match = (wsel_ex == rs_id) || (wsel_ex == rt_id);
  assign lu_c        = w_dest_live && w_src_match;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: freeze, load-use stall, redirect flush, halt.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl
  import diaosi_types_pkg::*;
#(
  parameter int unsigned REGBITS = REG_W
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  parameter int unsigned CNTW    = 32
`endif
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic [REGBITS-1:0] rs_id,
  input  logic [REGBITS-1:0] rt_id,
  input  logic               d_ren_ex,
  input  logic [REGBITS-1:0] wsel_ex,
  input  logic               redirect_ex,
  input  logic               dreq_mem,
  input  logic               halt_mem,
  output logic               if_en,
  output logic               id_en,
  output logic               ex_en,
  output logic               mem_en,
  output logic               id_bubble,
  output logic               ifid_flush,
  output logic               dmem_mask,
  output logic               halt
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [CNTW-1:0]    stall_cnt,
  output logic [CNTW-1:0]    flush_cnt,
  output logic [CNTW-1:0]    cycle_cnt
`endif
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;
  logic        r_hit_seen;
  logic        w_adv;
  logic        w_lu;

  load_use_detect #(
    .REGBITS (REGBITS)
  ) u_lu (
    .d_ren_ex (d_ren_ex),
    .wsel_ex  (wsel_ex),
    .rs_id    (rs_id),
    .rt_id    (rt_id),
    .lu_c     (w_lu)
  );

  // A data access that already completed no longer holds the pipeline.
  assign w_adv     = ihit && (!dreq_mem || dhit || r_hit_seen);
  assign dmem_mask = r_hit_seen;
  assign halt      = (r_state == HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Remember a dhit pulse that arrived while fetch was still waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_seen <= 1'b0;
    end else if (w_adv) begin
      r_hit_seen <= 1'b0;
    end else if (dhit) begin
      r_hit_seen <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if_en       = 1'b0;
    id_en       = 1'b0;
    ex_en       = 1'b0;
    mem_en      = 1'b0;
    id_bubble   = 1'b0;
    ifid_flush  = 1'b0;
    case (r_state)
      HALTED: begin
        w_state_nxt = HALTED;
      end
      RUN, MEM_WAIT: begin
        if (!w_adv) begin
          w_state_nxt = dreq_mem ? MEM_WAIT : RUN;
        end else begin
          w_state_nxt = halt_mem ? HALTED : RUN;
          id_en       = 1'b1;
          ex_en       = 1'b1;
          mem_en      = 1'b1;
          if (redirect_ex) begin
            // IF/ID is discarded, so any load-use against it is moot.
            if_en      = 1'b1;
            ifid_flush = 1'b1;
            id_bubble  = 1'b1;
          end else if (w_lu) begin
            id_bubble  = 1'b1;
          end else begin
            if_en      = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNTW-1:0] r_stall_cnt;
  logic [CNTW-1:0] r_flush_cnt;
  logic [CNTW-1:0] r_cycle_cnt;
  logic            w_live;

  assign w_live = (r_state != HALTED);

  // Saturating event counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if (w_live && (r_cycle_cnt != '1)) begin
        r_cycle_cnt <= r_cycle_cnt + CNTW'(1);
      end
      if (w_live && !if_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNTW'(1);
      end
      if (ifid_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNTW'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign cycle_cnt = r_cycle_cnt;
`endif

endmodule
